// File: rtl/l2k_mem_pkg.sv
// Shared definitions for the Limn2600 RAM-side bridge.
//   sram_state_t : bridge FSM states
//   HALF_LO/HI   : halfword select (half 0 = low 16 bits, little-endian)
package l2k_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4,
        ST_RECOVER = 3'd5
    } sram_state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/l2k_sram_bridge.sv
// Executes the scheduler's single-outstanding 32-bit RAM commands on a
// 16-bit asynchronous SRAM, low halfword first, with WAIT_STATES extra
// strobe cycles per halfword.
// Ports:
//   clk, rst                 clock, async active-high reset
//   mem_addr/wdata/we/ce     command from scheduler (held until mem_rdy)
//   mem_rdata, mem_rdy       read data and one-cycle completion pulse
//   sram_addr                halfword address
//   sram_dq_out/oe, dq_in    data pads
//   sram_ce_n/oe_n/we_n      active-low strobes (registered, glitch-free)
module l2k_sram_bridge
    import l2k_mem_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_we,
    input  logic              mem_ce,
    output logic [31:0]       mem_rdata,
    output logic              mem_rdy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    sram_state_t       state_r;
    sram_state_t       state_next_s;
    logic [3:0]        wait_cnt_r;
    logic              half_r;
    logic [ADDR_W-2:0] addr_r;
    logic [31:0]       wdata_r;
    logic              we_r;
    logic [31:0]       shadow_r;
    logic              strobe_last_s;
    logic              cmd_we_s;
    logic              busy_next_s;
    logic              latch_s;
    logic              next_half_s;

    assign strobe_last_s = (wait_cnt_r == WAIT_LAST);
    assign latch_s       = (state_r == ST_IDLE) && mem_ce;
    assign next_half_s   = (state_r == ST_HOLD) && (half_r == HALF_LO);
    // In IDLE the command is not latched yet, so pad enables for the
    // upcoming SETUP cycle must look at mem_we directly.
    assign cmd_we_s      = (state_r == ST_IDLE) ? mem_we : we_r;

    // Next-state logic; DONE and RECOVER ignore mem_ce (stale command).
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_ce) state_next_s = ST_SETUP;
                else        state_next_s = ST_IDLE;
            end
            ST_SETUP:   state_next_s = ST_STROBE;
            ST_STROBE: begin
                if (strobe_last_s) state_next_s = ST_HOLD;
                else               state_next_s = ST_STROBE;
            end
            ST_HOLD: begin
                if (half_r == HALF_LO) state_next_s = ST_SETUP;
                else                   state_next_s = ST_DONE;
            end
            ST_DONE:    state_next_s = ST_RECOVER;
            ST_RECOVER: state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // The SRAM is selected for the whole of both halfword accesses.
    always_comb begin
        busy_next_s = 1'b0;
        case (state_next_s)
            ST_SETUP, ST_STROBE, ST_HOLD: busy_next_s = 1'b1;
            default:                      busy_next_s = 1'b0;
        endcase
    end

    // FSM state, wait counter, half select and command latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            half_r     <= HALF_LO;
            addr_r     <= '0;
            wdata_r    <= 32'd0;
            we_r       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_STROBE && !strobe_last_s) wait_cnt_r <= wait_cnt_r + 4'd1;
            else                                        wait_cnt_r <= 4'd0;
            if (latch_s) begin
                addr_r  <= mem_addr[ADDR_W:2];
                wdata_r <= mem_wdata;
                we_r    <= mem_we;
                half_r  <= HALF_LO;
            end else if (next_half_s) begin
                half_r <= HALF_HI;
            end
        end
    end

    // Read capture on the last strobe edge, after W+1 cycles of oe_n low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r <= 32'd0;
        end else if (state_r == ST_STROBE && strobe_last_s && !we_r) begin
            if (half_r == HALF_LO) shadow_r[15:0]  <= sram_dq_in;
            else                   shadow_r[31:16] <= sram_dq_in;
        end
    end

    // Pad registers, driven from the next state so strobes line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr   <= '0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            if (latch_s) begin
                sram_addr   <= {mem_addr[ADDR_W:2], HALF_LO};
                sram_dq_out <= mem_wdata[15:0];
            end else if (next_half_s) begin
                sram_addr   <= {addr_r, HALF_HI};
                sram_dq_out <= wdata_r[31:16];
            end
            sram_ce_n  <= !busy_next_s;
            sram_dq_oe <= busy_next_s && cmd_we_s;
            sram_oe_n  <= !((state_next_s == ST_STROBE) && !cmd_we_s);
            sram_we_n  <= !((state_next_s == ST_STROBE) && cmd_we_s);
        end
    end

    // Completion pulse; read data holds until the next read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdy   <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            mem_rdy <= (state_next_s == ST_DONE);
            if (state_next_s == ST_DONE && !we_r) mem_rdata <= shadow_r;
        end
    end

endmodule

// File: tb/tb_l2k_sram_bridge.sv
// Scoreboard bench for l2k_sram_bridge with a behavioural 16-bit SRAM.
module tb_l2k_sram_bridge;
    localparam int ADDR_W = 18;
    localparam int W      = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic              mem_we, mem_ce, mem_rdy;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_out, sram_dq_in;
    logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    l2k_sram_bridge #(.ADDR_W(ADDR_W), .WAIT_STATES(W)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ce(mem_ce),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM.
    logic [15:0] sram_mem [0:(1<<ADDR_W)-1];
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0000;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        int          rdy_cyc;
    } exp_t;
    exp_t sb_q[$];

    logic cur_we = 1'b0;
    int   ce_falls = 0;
    int   pulses   = 0;

    // Scoreboard monitor: every mem_rdy pops one expected completion.
    initial forever begin
        @(negedge clk);
        if (!rst && mem_rdy) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("mem_rdata", mem_rdata, e.rdata);
                chk("rdy_cycle", 32'(cyc), 32'(e.rdy_cyc));
            end
        end
    end

    // Pad protocol monitor: strobe widths, setup/hold, bus turnaround.
    initial begin
        int we_cnt, oe_cnt, ce_cnt;
        logic prev_ce_n, prev_we_n, prev_oe;
        logic [ADDR_W-1:0] we_addr;
        we_cnt = 0; oe_cnt = 0; ce_cnt = 0;
        prev_ce_n = 1'b1; prev_we_n = 1'b1; prev_oe = 1'b0; we_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                we_cnt = 0; oe_cnt = 0; ce_cnt = 0;
                prev_ce_n = 1'b1; prev_we_n = 1'b1; prev_oe = 1'b0;
            end else begin
                if (!sram_oe_n) chk("turnaround_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
                if (!cur_we && !sram_ce_n) chk("read_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
                if (!sram_we_n && prev_we_n) begin
                    chk("we_setup_ce", {31'd0, prev_ce_n}, 32'd0);
                    chk("we_setup_oe", {31'd0, prev_oe}, 32'd1);
                    we_addr = sram_addr;
                end
                if (!sram_we_n) we_cnt++;
                else if (we_cnt > 0) begin
                    chk("we_n_width", 32'(we_cnt), 32'(W + 1));
                    chk("we_hold_ce", {31'd0, sram_ce_n}, 32'd0);
                    chk("we_hold_addr", 32'(sram_addr), 32'(we_addr));
                    we_cnt = 0; pulses++;
                end
                if (!sram_oe_n) oe_cnt++;
                else if (oe_cnt > 0) begin
                    chk("oe_n_width", 32'(oe_cnt), 32'(W + 1));
                    oe_cnt = 0; pulses++;
                end
                if (!sram_ce_n && prev_ce_n) ce_falls++;
                if (!sram_ce_n) ce_cnt++;
                else if (ce_cnt > 0) begin
                    chk("ce_n_width", 32'(ce_cnt), 32'(2 * W + 6));
                    ce_cnt = 0;
                end
                prev_ce_n = sram_ce_n; prev_we_n = sram_we_n; prev_oe = sram_dq_oe;
            end
        end
    end

    // Issue one command at a negedge in IDLE; returns at the next IDLE negedge
    // with mem_ce still high (the scheduler holds it through RECOVER).
    task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, output int rdy_cyc);
        int ce0, p0;
        bit got;
        exp_t e;
        ce0 = ce_falls; p0 = pulses;
        mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_ce = 1'b1; cur_we = we;
        e.rdata = exp_rdata;
        e.rdy_cyc = cyc + 1 + 2 * W + 6;
        sb_q.push_back(e);
        got = 1'b0;
        rdy_cyc = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                // Post-latch input changes must be ignored.
                mem_addr = ~addr; mem_wdata = ~wdata; mem_we = ~we;
            end
            if (mem_rdy) begin
                got = 1'b1;
                rdy_cyc = cyc;
            end
        end
        if (!got) chk("rdy_timeout", 32'd0, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("one_access", 32'(ce_falls - ce0), 32'd1);
        chk("two_strobes", 32'(pulses - p0), 32'd2);
    endtask

    task automatic idle_gap();
        mem_ce = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r1, r2;
        bit hit;
        rst = 1'b1; mem_ce = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_rdy", {31'd0, mem_rdy}, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write, then read back; rdata holds across a later write.
        run_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, r1);
        idle_gap();
        chk("sram_hw8", {16'd0, sram_mem[8]}, 32'h0000_BEEF);
        chk("sram_hw9", {16'd0, sram_mem[9]}, 32'h0000_DEAD);
        run_cmd(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, r1);
        idle_gap();
        run_cmd(1'b1, 32'h0000_0014, 32'h0102_0304, 32'hDEAD_BEEF, r1);
        idle_gap();

        // Back-to-back reads with mem_ce held continuously.
        run_cmd(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, r1);
        run_cmd(1'b0, 32'h0000_0014, 32'h0, 32'h0102_0304, r2);
        chk("b2b_spacing", 32'(r2 - r1), 32'(2 * W + 9));
        idle_gap();

        // Upper address bits alias.
        run_cmd(1'b1, 32'h0008_0010, 32'h1234_5678, 32'h0102_0304, r1);
        idle_gap();
        chk("alias_hw8", {16'd0, sram_mem[8]}, 32'h0000_5678);
        chk("alias_hw9", {16'd0, sram_mem[9]}, 32'h0000_1234);
        run_cmd(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, r1);
        idle_gap();

        // Reset during the high-half strobe of a write.
        mem_we = 1'b1; mem_addr = 32'h0000_0020; mem_wdata = 32'hCAFE_F00D; mem_ce = 1'b1; cur_we = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (!sram_we_n && sram_addr[0]) hit = 1'b1;
        end
        chk("hi_strobe_reached", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        chk("rst_mid_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_mid_rdy", {31'd0, mem_rdy}, 32'd0);
        mem_ce = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_low_half_committed", {16'd0, sram_mem[16]}, 32'h0000_F00D);

        // Next command after reset completes normally.
        run_cmd(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, r1);
        idle_gap();
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
